rv_mem_responder: RTL and testbench

Memory-side responder for the rv core's load/store interface: shared 32-bit tri-state `bus`, 32-bit `addr`, and `read`/`write` strobes. Holds a word-organised, little-endian RAM. Services byte, half and word accesses with configurable wait states. Returns a `ready`/`fault` handshake and drives `bus` only while returning load data. Sits on the core's data port in place of the bench-driven bus.

---
 rtl/rv_mem_responder.sv | 157 +++++++++++++++
 tb/tb_rv_mem_responder.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/rv_mem_responder.sv
// Word-organised little-endian RAM on the core's tri-state load/store bus; byte/half/word with sign/zero extension.
// Latency: ready first high WAIT_STATES+1 cycles after the strobe-accept edge; strobe must drop before the next access.
// Backpressure: core holds read/write until ready; dropping the strobe during WAIT aborts the access.
module rv_mem_responder #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    inout  wire  [31:0] bus,
    input  logic        read,
    input  logic        write,
    input  logic [2:0]  funct3,
    output logic        ready,
    output logic        fault
);
    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP, HOLD} state_t;
    state_t state, state_nxt;

    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] addr_q, rdata_q;
    logic [2:0]  f3_q;
    logic        load_q, both_q, fault_q;
    logic [3:0]  cnt;
    logic        accept, enter_resp, commit;

    // Decode from live inputs in IDLE so the zero-wait-state path sees the access on its accept edge.
    logic [31:0] cur_addr, off;
    logic [2:0]  cur_f3;
    logic        cur_load, cur_both, f3_ok, misal, oor, fault_calc;
    logic [AW-1:0] idx;

    always_comb begin
        cur_addr   = (state == IDLE) ? addr   : addr_q;
        cur_f3     = (state == IDLE) ? funct3 : f3_q;
        cur_load   = (state == IDLE) ? read   : load_q;
        cur_both   = (state == IDLE) ? (read & write) : (both_q | (read & write));
        f3_ok      = cur_load ? (cur_f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})
                              : (cur_f3 inside {3'b000, 3'b001, 3'b010});
        misal      = ((cur_f3[1:0] == 2'b01) && cur_addr[0]) ||
                     ((cur_f3[1:0] == 2'b10) && (cur_addr[1:0] != 2'b00));
        off        = cur_addr - BASE_ADDR;
        oor        = (cur_addr < BASE_ADDR) || ((off >> 2) >= 32'(DEPTH_WORDS));
        fault_calc = cur_both | ~f3_ok | misal | oor;
        idx        = off[AW+1:2];
    end

    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        enter_resp = 1'b0;
        commit     = 1'b0;
        case (state)
            IDLE: if (read | write) begin
                accept = 1'b1;
                if (WAIT_STATES == 0) begin
                    state_nxt  = RESP;
                    enter_resp = 1'b1;
                end else begin
                    state_nxt = WAIT;
                end
            end
            WAIT: if (!read && !write) begin
                state_nxt = IDLE;
            end else if (cnt == 4'd1) begin
                state_nxt  = RESP;
                enter_resp = 1'b1;
            end
            RESP: begin
                state_nxt = HOLD;
                commit    = ~fault_q & ~load_q;
            end
            HOLD: if (!read && !write) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            fault_q <= 1'b0;
            both_q  <= 1'b0;
            load_q  <= 1'b0;
            addr_q  <= '0;
            f3_q    <= '0;
            rdata_q <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                addr_q <= addr;
                f3_q   <= funct3;
                load_q <= read;
                both_q <= read & write;
                cnt    <= 4'(WAIT_STATES);
            end
            if (state == WAIT) begin
                cnt    <= cnt - 4'd1;
                both_q <= both_q | (read & write);
            end
            if (enter_resp) begin
                fault_q <= fault_calc;
                rdata_q <= fault_calc ? 32'd0 : mem[idx];
            end
            if (state == HOLD && state_nxt == IDLE) fault_q <= 1'b0;
        end
    end

    // Store lanes: replicate the right-aligned data and enable only the addressed bytes.
    logic [3:0]  be;
    logic [31:0] wdat;
    always_comb begin
        be   = 4'b0000;
        wdat = bus;
        case (f3_q[1:0])
            2'b00: begin
                be   = 4'b0001 << addr_q[1:0];
                wdat = {4{bus[7:0]}};
            end
            2'b01: begin
                be   = addr_q[1] ? 4'b1100 : 4'b0011;
                wdat = {2{bus[15:0]}};
            end
            default: be = 4'b1111;
        endcase
    end

    always_ff @(posedge clk) begin
        if (commit && !rst) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[idx][8*b +: 8] <= wdat[8*b +: 8];
            end
        end
    end

    logic [31:0] lane, load_dat;
    logic        drive;
    always_comb begin
        lane = rdata_q >> {addr_q[1:0], 3'b000};
        case (f3_q)
            3'b000:  load_dat = {{24{lane[7]}}, lane[7:0]};
            3'b001:  load_dat = {{16{lane[15]}}, lane[15:0]};
            3'b100:  load_dat = {24'd0, lane[7:0]};
            3'b101:  load_dat = {16'd0, lane[15:0]};
            default: load_dat = rdata_q;
        endcase
    end

    assign ready = (state == RESP) || (state == HOLD);
    assign fault = fault_q & ready;
    assign drive = ready & load_q & ~fault_q & read;
    assign bus   = drive ? load_dat : 32'bz;
endmodule

// File: tb/tb_rv_mem_responder.sv
// Bench for rv_mem_responder: three builds (0, 1 and 3 wait states) share one stimulus set, selected by sel.
module tb_rv_mem_responder;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ad, tb_dat;
    logic [2:0]  f3;
    logic        rd, wr, tb_oe;
    logic [1:0]  sel;
    int          pass_cnt = 0;
    int          total = 0;

    always #5 clk = ~clk;

    wire  [31:0] bus0, bus1, bus3;
    logic        rdy0, rdy1, rdy3, flt0, flt1, flt3;
    logic        rd0, rd1, rd3, wr0, wr1, wr3;
    logic        rdy, flt;
    logic [31:0] bus_obs;

    pullup (bus0);
    pullup (bus1);
    pullup (bus3);
    assign bus0 = (tb_oe && sel == 2'd0) ? tb_dat : 32'bz;
    assign bus1 = (tb_oe && sel == 2'd1) ? tb_dat : 32'bz;
    assign bus3 = (tb_oe && sel == 2'd3) ? tb_dat : 32'bz;
    assign rd0 = rd & (sel == 2'd0);
    assign rd1 = rd & (sel == 2'd1);
    assign rd3 = rd & (sel == 2'd3);
    assign wr0 = wr & (sel == 2'd0);
    assign wr1 = wr & (sel == 2'd1);
    assign wr3 = wr & (sel == 2'd3);
    assign rdy     = (sel == 2'd0) ? rdy0 : (sel == 2'd1) ? rdy1 : rdy3;
    assign flt     = (sel == 2'd0) ? flt0 : (sel == 2'd1) ? flt1 : flt3;
    assign bus_obs = (sel == 2'd0) ? bus0 : (sel == 2'd1) ? bus1 : bus3;

    rv_mem_responder #(.WAIT_STATES(0)) u0 (.clk(clk), .rst(rst), .addr(ad), .bus(bus0),
        .read(rd0), .write(wr0), .funct3(f3), .ready(rdy0), .fault(flt0));
    rv_mem_responder #(.WAIT_STATES(1)) u1 (.clk(clk), .rst(rst), .addr(ad), .bus(bus1),
        .read(rd1), .write(wr1), .funct3(f3), .ready(rdy1), .fault(flt1));
    rv_mem_responder #(.WAIT_STATES(3)) u3 (.clk(clk), .rst(rst), .addr(ad), .bus(bus3),
        .read(rd3), .write(wr3), .funct3(f3), .ready(rdy3), .fault(flt3));

    int          lat;
    logic        fo, held, after;
    logic [31:0] rv;

    // Drives one full access; lat counts negedges from the accept edge to first ready (-1 on timeout).
    task automatic do_access(input logic ld, input logic st, input logic [2:0] f, input logic [31:0] a,
                             input logic [31:0] wd);
        @(negedge clk);
        ad = a; f3 = f; rd = ld; wr = st; tb_dat = wd; tb_oe = st;
        @(posedge clk);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (rdy) begin
                lat = i;
                break;
            end
        end
        fo = flt; rv = bus_obs;
        @(negedge clk);
        held = rdy;
        rd = 1'b0; wr = 1'b0; tb_oe = 1'b0;
        @(negedge clk);
        after = rdy;
    endtask

    task automatic test_reset;
        rst = 1'b1; rd = 1'b0; wr = 1'b0; tb_oe = 1'b0; ad = '0; f3 = '0; tb_dat = '0; sel = 2'd1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 4; s++) begin
            if (s == 2) continue;
            sel = 2'(s);
            #1;
            total++; if (rdy !== 1'b0) $display("FAIL reset_ready[%0d]: got %b want 0", s, rdy); else pass_cnt++;
            total++; if (flt !== 1'b0) $display("FAIL reset_fault[%0d]: got %b want 0", s, flt); else pass_cnt++;
            total++; if (bus_obs !== 32'hFFFF_FFFF) $display("FAIL reset_bus[%0d]: got %h want released", s, bus_obs); else pass_cnt++;
        end
        rst = 1'b0;
        sel = 2'd1;
    endtask

    task automatic test_word;
        do_access(1'b0, 1'b1, 3'b010, 32'd0, 32'd42);
        total++; if (lat !== 2) $display("FAIL sw0_latency: got %0d want 2", lat); else pass_cnt++;
        total++; if (fo !== 1'b0) $display("FAIL sw0_fault: got %b want 0", fo); else pass_cnt++;
        do_access(1'b1, 1'b0, 3'b010, 32'd0, 32'd0);
        total++; if (lat !== 2) $display("FAIL lw0_latency: got %0d want 2", lat); else pass_cnt++;
        total++; if (rv !== 32'd42) $display("FAIL lw0_data: got %h want %h", rv, 32'd42); else pass_cnt++;
        total++; if (fo !== 1'b0) $display("FAIL lw0_fault: got %b want 0", fo); else pass_cnt++;
        total++; if (held !== 1'b1 || after !== 1'b0) $display("FAIL lw0_hold: got %b%b want 10", held, after); else pass_cnt++;
    endtask

    task automatic test_bytes;
        do_access(1'b0, 1'b1, 3'b010, 32'd4, 32'h0);
        do_access(1'b0, 1'b1, 3'b000, 32'd5, 32'h1234_56A5);
        do_access(1'b1, 1'b0, 3'b010, 32'd4, 32'd0);
        total++; if (rv !== 32'h0000_A500) $display("FAIL lw4: got %h want 0000a500", rv); else pass_cnt++;
        do_access(1'b1, 1'b0, 3'b000, 32'd5, 32'd0);
        total++; if (rv !== 32'hFFFF_FFA5) $display("FAIL lb5: got %h want ffffffa5", rv); else pass_cnt++;
        do_access(1'b1, 1'b0, 3'b100, 32'd5, 32'd0);
        total++; if (rv !== 32'h0000_00A5) $display("FAIL lbu5: got %h want 000000a5", rv); else pass_cnt++;
        do_access(1'b1, 1'b0, 3'b001, 32'd4, 32'd0);
        total++; if (rv !== 32'hFFFF_A500) $display("FAIL lh4: got %h want ffffa500", rv); else pass_cnt++;
        do_access(1'b1, 1'b0, 3'b101, 32'd4, 32'd0);
        total++; if (rv !== 32'h0000_A500) $display("FAIL lhu4: got %h want 0000a500", rv); else pass_cnt++;
        do_access(1'b0, 1'b1, 3'b001, 32'd6, 32'hCAFE_8001);
        do_access(1'b1, 1'b0, 3'b010, 32'd4, 32'd0);
        total++; if (rv !== 32'h8001_A500) $display("FAIL sh6_lw4: got %h want 8001a500", rv); else pass_cnt++;
        do_access(1'b1, 1'b0, 3'b001, 32'd6, 32'd0);
        total++; if (rv !== 32'hFFFF_8001) $display("FAIL lh6: got %h want ffff8001", rv); else pass_cnt++;
    endtask

    task automatic test_faults;
        do_access(1'b1, 1'b0, 3'b010, 32'd2, 32'd0);
        total++; if (fo !== 1'b1 || lat !== 2) $display("FAIL lw2_fault: got %b lat %0d want 1 lat 2", fo, lat); else pass_cnt++;
        total++; if (rv !== 32'hFFFF_FFFF) $display("FAIL lw2_bus: got %h want released", rv); else pass_cnt++;
        do_access(1'b0, 1'b1, 3'b001, 32'd7, 32'h0000_1111);
        total++; if (fo !== 1'b1) $display("FAIL sh7_fault: got %b want 1", fo); else pass_cnt++;
        do_access(1'b1, 1'b0, 3'b010, 32'd4, 32'd0);
        total++; if (rv !== 32'h8001_A500) $display("FAIL sh7_ram: got %h want 8001a500", rv); else pass_cnt++;
        do_access(1'b1, 1'b1, 3'b010, 32'd0, 32'h5555_5555);
        total++; if (fo !== 1'b1) $display("FAIL rw_both_fault: got %b want 1", fo); else pass_cnt++;
        do_access(1'b1, 1'b0, 3'b010, 32'd0, 32'd0);
        total++; if (rv !== 32'd42) $display("FAIL rw_both_ram: got %h want %h", rv, 32'd42); else pass_cnt++;
        do_access(1'b1, 1'b0, 3'b010, 32'h0000_1000, 32'd0);
        total++; if (fo !== 1'b1 || rv !== 32'hFFFF_FFFF) $display("FAIL oor: got %b %h want 1 released", fo, rv); else pass_cnt++;
        do_access(1'b1, 1'b0, 3'b010, 32'h0000_0FFC, 32'd0);
        total++; if (fo !== 1'b0) $display("FAIL last_word: got %b want 0", fo); else pass_cnt++;
        do_access(1'b1, 1'b0, 3'b011, 32'd0, 32'd0);
        total++; if (fo !== 1'b1) $display("FAIL ld_f3_011: got %b want 1", fo); else pass_cnt++;
        do_access(1'b0, 1'b1, 3'b100, 32'd0, 32'h0000_0077);
        total++; if (fo !== 1'b1) $display("FAIL st_f3_100: got %b want 1", fo); else pass_cnt++;
        total++; if (held !== 1'b1 || after !== 1'b0) $display("FAIL fault_release: got %b%b want 10", held, after); else pass_cnt++;
    endtask

    task automatic test_wait0;
        sel = 2'd0;
        do_access(1'b0, 1'b1, 3'b010, 32'h10, 32'h1122_3344);
        total++; if (lat !== 1) $display("FAIL w0_sw_latency: got %0d want 1", lat); else pass_cnt++;
        do_access(1'b1, 1'b0, 3'b000, 32'h13, 32'd0);
        total++; if (lat !== 1) $display("FAIL w0_lb_latency: got %0d want 1", lat); else pass_cnt++;
        total++; if (rv !== 32'h0000_0011) $display("FAIL w0_lb_data: got %h want 00000011", rv); else pass_cnt++;
        total++; if (held !== 1'b1 || after !== 1'b0) $display("FAIL w0_hold: got %b%b want 10", held, after); else pass_cnt++;
    endtask

    task automatic test_wait3;
        int seen;
        sel = 2'd3;
        do_access(1'b0, 1'b1, 3'b010, 32'd8, 32'h0BAD_F00D);
        total++; if (lat !== 4) $display("FAIL w3_sw_latency: got %0d want 4", lat); else pass_cnt++;
        total++; if (held !== 1'b1 || after !== 1'b0) $display("FAIL w3_hold: got %b%b want 10", held, after); else pass_cnt++;
        // Abort during WAIT
        @(negedge clk);
        ad = 32'd8; f3 = 3'b010; wr = 1'b1; tb_dat = 32'hDEAD_BEEF; tb_oe = 1'b1;
        @(posedge clk);
        @(negedge clk);
        wr = 1'b0; tb_oe = 1'b0;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (rdy) seen++;
        end
        total++; if (seen !== 0) $display("FAIL w3_abort_ready: got %0d ready cycles want 0", seen); else pass_cnt++;
        do_access(1'b1, 1'b0, 3'b010, 32'd8, 32'd0);
        total++; if (rv !== 32'h0BAD_F00D) $display("FAIL w3_abort_ram: got %h want 0badf00d", rv); else pass_cnt++;
        // Reset while the store sits in RESP
        @(negedge clk);
        ad = 32'd8; f3 = 3'b010; wr = 1'b1; tb_dat = 32'hDEAD_BEEF; tb_oe = 1'b1;
        @(posedge clk);
        seen = 0;
        for (int i = 0; i < 20 && !rdy; i++) @(negedge clk);
        if (rdy) seen = 1;
        rst = 1'b1;
        @(negedge clk);
        total++; if (seen !== 1 || rdy !== 1'b0) $display("FAIL w3_rst_store_ready: got seen %0d ready %b want 1 0", seen, rdy); else pass_cnt++;
        rst = 1'b0; wr = 1'b0; tb_oe = 1'b0;
        do_access(1'b1, 1'b0, 3'b010, 32'd8, 32'd0);
        total++; if (rv !== 32'h0BAD_F00D) $display("FAIL w3_rst_ram: got %h want 0badf00d", rv); else pass_cnt++;
        // Reset while load data is on the bus
        @(negedge clk);
        ad = 32'd8; f3 = 3'b010; rd = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 20 && !rdy; i++) @(negedge clk);
        total++; if (bus_obs !== 32'h0BAD_F00D) $display("FAIL w3_load_drive: got %h want 0badf00d", bus_obs); else pass_cnt++;
        rst = 1'b1;
        @(negedge clk);
        total++; if (rdy !== 1'b0 || bus_obs !== 32'hFFFF_FFFF) $display("FAIL w3_rst_load: got %b %h want 0 released", rdy, bus_obs); else pass_cnt++;
        rst = 1'b0; rd = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_word();
        test_bytes();
        test_faults();
        test_wait0();
        test_wait3();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
